flag_producer: RTL

// - Producer side of the Flags interface that condition_checker consumes.
// - Accepts compare operands from execute and computes NZCV as SrcA - SrcB

---
 rtl/flag_pkg.sv | 19 +
 rtl/flag_producer_if.sv | 15 +
 rtl/flag_producer_nzcv_gen.sv | 25 ++
 rtl/flag_producer.sv | 89 ++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// Flag types and bit positions shared by flag_producer and condition_checker.
// Flags are packed {N,Z,C,V}, so bit3..bit0 match the FLAG_* positions below.
package flag_pkg;

  typedef struct packed {
    logic N;
    logic Z;
    logic C;
    logic V;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam flags_t RESET_FLAGS = '0;

endpackage

// File: rtl/flag_producer_if.sv
// Compare-operand handshake from execute into the flag producer.
// master = execute side, slave = flag_producer.
interface flag_producer_if #(
  parameter int DATA_W = 32
);

  logic              cmp_valid;
  logic              cmp_ready;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;

  modport master (output cmp_valid, output src_a, output src_b, input cmp_ready);
  modport slave  (input cmp_valid, input src_a, input src_b, output cmp_ready);

endinterface

// File: rtl/flag_producer_nzcv_gen.sv
// Purpose: NZCV of a - b, computed as a + ~b + 1 on DATA_W+1 bits.
// Latency: combinational.
// Backpressure: none.
module nzcv_gen
  import flag_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output flags_t            nzcv
);

  logic [DATA_W:0] d;

  always_comb begin
    d      = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
    nzcv.N = d[DATA_W-1];
    nzcv.Z = (d[DATA_W-1:0] == '0);
    // carry out of the wide sum is the ARM-style "no borrow" C
    nzcv.C = d[DATA_W];
    nzcv.V = (a[DATA_W-1] ^ b[DATA_W-1]) & (a[DATA_W-1] ^ d[DATA_W-1]);
  end

endmodule

// File: rtl/flag_producer.sv
// Purpose: 2-stage compare pipeline producing architectural NZCV flags (optional FLAG_BYPASS_EN).
// Latency: accept at edge T -> flag_reg written at edge T+2 (Flags from T+1 with FLAG_BYPASS_EN).
// Backpressure: cmp_ready = ~stall; stall freezes both stages and flag_reg, flush kills stage 1.
module flag_producer
  import flag_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  flag_producer_if.slave        cmp,
  input  logic                  stall,
  input  logic                  flush,
  output flags_t                Flags,
  output logic                  FlagsValid,
  output logic                  FlagsPending
);

  logic              accept;
  logic              s1_valid;
  logic              s2_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [DATA_W-1:0] s2_a;
  logic [DATA_W-1:0] s2_b;
  flags_t            nzcv_now;
  flags_t            flag_reg;
  logic              flag_written;

  assign cmp.cmp_ready = ~stall;
  // a flushed cycle never accepts, even if execute presents operands
  assign accept        = cmp.cmp_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      flag_reg     <= RESET_FLAGS;
      flag_written <= 1'b0;
    end else begin
      // flush wins over stall for stage 1; accept is already 0 when flushing
      if (flush || !stall) begin
        s1_valid <= accept;
      end
      if (!stall) begin
        s2_valid <= s1_valid & ~flush;
        if (s2_valid) begin
          flag_reg     <= nzcv_now;
          flag_written <= 1'b1;
        end
      end
    end
  end

  // Operand registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a <= cmp.src_a;
      s1_b <= cmp.src_b;
    end
    if (!stall && s1_valid) begin
      s2_a <= s1_a;
      s2_b <= s1_b;
    end
  end

  nzcv_gen #(
    .DATA_W (DATA_W)
  ) u_nzcv_gen (
    .a    (s2_a),
    .b    (s2_b),
    .nzcv (nzcv_now)
  );

`ifdef FLAG_BYPASS_EN
  logic bypass;

  // forward the stage-2 result in the cycle it is being written
  assign bypass       = s2_valid & ~stall;
  assign Flags        = bypass ? nzcv_now : flag_reg;
  assign FlagsValid   = flag_written | bypass;
  assign FlagsPending = s1_valid;
`else
  assign Flags        = flag_reg;
  assign FlagsValid   = flag_written;
  assign FlagsPending = s1_valid | s2_valid;
`endif

endmodule
